// File: rtl/framed_stack_if.sv
// Command and result bundle for framed_stack: op/data/arg in, stack view and status out.
interface framed_stack_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 6,
    parameter int FDEPTH = 4
);
    logic [3:0]       op_i;
    logic [WIDTH-1:0] data_i;
    logic [DEPTH:0]   arg_i;
    logic [DEPTH:0]   index_o;
    logic [DEPTH:0]   base_o;
    logic [FDEPTH:0]  frame_o;
    logic [WIDTH-1:0] tos_o;
    logic [WIDTH-1:0] nos_o;
    logic [WIDTH-1:0] get_data_o;
    logic [3:0]       status_o;

    modport master (
        output op_i, data_i, arg_i,
        input  index_o, base_o, frame_o, tos_o, nos_o, get_data_o, status_o
    );

    modport slave (
        input  op_i, data_i, arg_i,
        output index_o, base_o, frame_o, tos_o, nos_o, get_data_o, status_o
    );
endinterface

// File: rtl/framed_stack.sv
// Operand stack with call-frame records: one op per cycle, top two entries cached in registers.
module framed_stack #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 6,
    parameter int FDEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    framed_stack_if.slave bus
);
    localparam int MAX  = 1 << DEPTH;
    localparam int FMAX = 1 << FDEPTH;
    localparam logic [DEPTH:0]   MAX_IDX  = (DEPTH+1)'(MAX);
    localparam logic [FDEPTH:0]  FMAX_CNT = (FDEPTH+1)'(FMAX);
    localparam logic [DEPTH:0]   ONE      = (DEPTH+1)'(1);
    localparam logic [DEPTH:0]   TWO      = (DEPTH+1)'(2);
    localparam logic [DEPTH:0]   THREE    = (DEPTH+1)'(3);
    localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);
    localparam logic [DEPTH-1:0] ADDR_TWO = DEPTH'(2);
    localparam logic [DEPTH-1:0] ADDR_THR = DEPTH'(3);
    localparam logic [FDEPTH:0]  FONE     = (FDEPTH+1)'(1);

    typedef enum logic [3:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_POP2_PUSH,
        OP_ENTER, OP_LEAVE, OP_GET, OP_SET
    } op_e;

    typedef enum logic [3:0] {
        ST_NONE, ST_EMPTY, ST_FULL, ST_UNDERFLOW, ST_OVERFLOW,
        ST_BAD_OFFSET, ST_FRAME_OVERFLOW, ST_FRAME_UNDERFLOW, ST_BAD_OP
    } status_e;

    logic [WIDTH-1:0] mem_q [MAX];
    logic [DEPTH:0]   savedBase_q [FMAX];

    logic [DEPTH:0]   index_q, index_d, base_q, base_d;
    logic [FDEPTH:0]  frame_q, frame_d;
    logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d, getData_q, getData_d;
    status_e          status_q, status_d, errCode;
    logic             hasErr;

    logic             memWe, frameWe;
    logic [DEPTH-1:0] memAddr;
    logic [WIDTH-1:0] memWdata;

    logic [DEPTH:0]   depthAvail;
    logic [DEPTH+1:0] offsetSum;
    logic             offsetOk;
    logic [WIDTH-1:0] belowIdx3, belowBase1, belowBase2;

    // Offsets are evaluated one bit wider so base+arg can never wrap into range.
    assign depthAvail = index_q - base_q;
    assign offsetSum  = {1'b0, base_q} + {1'b0, bus.arg_i};
    assign offsetOk   = offsetSum < {1'b0, index_q};
    assign belowIdx3  = (index_q >= THREE) ? mem_q[index_q[DEPTH-1:0] - ADDR_THR] : '0;
    assign belowBase1 = (base_q >= ONE) ? mem_q[base_q[DEPTH-1:0] - ADDR_ONE] : '0;
    assign belowBase2 = (base_q >= TWO) ? mem_q[base_q[DEPTH-1:0] - ADDR_TWO] : '0;

    always_comb begin
        index_d   = index_q;
        base_d    = base_q;
        frame_d   = frame_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        getData_d = getData_q;
        hasErr    = 1'b0;
        errCode   = ST_NONE;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        frameWe   = 1'b0;
        case (bus.op_i)
            OP_NOP: ;
            OP_PUSH:
                if (index_q == MAX_IDX) begin
                    hasErr = 1'b1; errCode = ST_OVERFLOW;
                end else begin
                    memWe = 1'b1; memAddr = index_q[DEPTH-1:0]; memWdata = bus.data_i;
                    index_d = index_q + ONE; nos_d = tos_q; tos_d = bus.data_i;
                end
            OP_POP:
                if (index_q == base_q) begin
                    hasErr = 1'b1; errCode = ST_UNDERFLOW;
                end else begin
                    index_d = index_q - ONE; tos_d = nos_q; nos_d = belowIdx3;
                end
            OP_REPLACE:
                if (index_q == base_q) begin
                    hasErr = 1'b1; errCode = ST_UNDERFLOW;
                end else begin
                    memWe = 1'b1; memAddr = index_q[DEPTH-1:0] - ADDR_ONE; memWdata = bus.data_i;
                    tos_d = bus.data_i;
                end
            OP_POP2_PUSH:
                if (depthAvail < TWO) begin
                    hasErr = 1'b1; errCode = ST_UNDERFLOW;
                end else begin
                    memWe = 1'b1; memAddr = index_q[DEPTH-1:0] - ADDR_TWO; memWdata = bus.data_i;
                    index_d = index_q - ONE; tos_d = bus.data_i; nos_d = belowIdx3;
                end
            OP_ENTER:
                if (frame_q == FMAX_CNT) begin
                    hasErr = 1'b1; errCode = ST_FRAME_OVERFLOW;
                end else if (bus.arg_i > depthAvail) begin
                    hasErr = 1'b1; errCode = ST_UNDERFLOW;
                end else begin
                    frameWe = 1'b1; frame_d = frame_q + FONE; base_d = index_q - bus.arg_i;
                end
            OP_LEAVE:
                if (frame_q == '0) begin
                    hasErr = 1'b1; errCode = ST_FRAME_UNDERFLOW;
                end else if (bus.arg_i > ONE) begin
                    hasErr = 1'b1; errCode = ST_BAD_OFFSET;
                end else if (bus.arg_i == ONE && index_q == base_q) begin
                    hasErr = 1'b1; errCode = ST_UNDERFLOW;
                end else begin
                    base_d  = savedBase_q[frame_q[FDEPTH-1:0] - FDEPTH'(1)];
                    frame_d = frame_q - FONE;
                    index_d = base_q + bus.arg_i;
                    // A kept result lands at the old base, so it sits on top of the caller's entries.
                    if (bus.arg_i == ONE) begin
                        memWe = 1'b1; memAddr = base_q[DEPTH-1:0]; memWdata = tos_q;
                        nos_d = belowBase1;
                    end else begin
                        tos_d = belowBase1; nos_d = belowBase2;
                    end
                end
            OP_GET:
                if (!offsetOk) begin
                    hasErr = 1'b1; errCode = ST_BAD_OFFSET;
                end else begin
                    getData_d = mem_q[offsetSum[DEPTH-1:0]];
                end
            OP_SET:
                if (!offsetOk) begin
                    hasErr = 1'b1; errCode = ST_BAD_OFFSET;
                end else begin
                    memWe = 1'b1; memAddr = offsetSum[DEPTH-1:0]; memWdata = bus.data_i;
                    if (offsetSum[DEPTH:0] == index_q - ONE) tos_d = bus.data_i;
                    if (offsetSum[DEPTH:0] == index_q - TWO) nos_d = bus.data_i;
                end
            default: begin
                hasErr = 1'b1; errCode = ST_BAD_OP;
            end
        endcase

        if (hasErr)                 status_d = errCode;
        else if (index_d == MAX_IDX) status_d = ST_FULL;
        else if (index_d == base_d)  status_d = ST_EMPTY;
        else                         status_d = ST_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q   <= '0;
            base_q    <= '0;
            frame_q   <= '0;
            tos_q     <= '0;
            nos_q     <= '0;
            getData_q <= '0;
            status_q  <= ST_EMPTY;
        end else begin
            index_q   <= index_d;
            base_q    <= base_d;
            frame_q   <= frame_d;
            tos_q     <= tos_d;
            nos_q     <= nos_d;
            getData_q <= getData_d;
            status_q  <= status_d;
        end
    end

    // Storage arrays are never cleared; reset only blocks writes on that edge.
    always_ff @(posedge clk) begin
        if (!reset && memWe)   mem_q[memAddr] <= memWdata;
        if (!reset && frameWe) savedBase_q[frame_q[FDEPTH-1:0]] <= base_q;
    end

    assign bus.index_o    = index_q;
    assign bus.base_o     = base_q;
    assign bus.frame_o    = frame_q;
    assign bus.tos_o      = tos_q;
    assign bus.nos_o      = nos_q;
    assign bus.get_data_o = getData_q;
    assign bus.status_o   = status_q;
endmodule

// File: doc/framed_stack.md
FRAMED_STACK -- requirements
Module: framed_stack

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 6, log2 of operand stack entries (MAX = 2^DEPTH).
REQ-003 Parameter FDEPTH, default 4, log2 of frame-record entries (FMAX = 2^FDEPTH).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 op  input  4  0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 POP2_PUSH, 5 ENTER, 6 LEAVE, 7 GET, 8 SET; 9-15 illegal.
REQ-007 data  input  WIDTH  value for PUSH/REPLACE/POP2_PUSH/SET.
REQ-008 arg  input  DEPTH+1  ENTER: number of argument entries; GET/SET: offset from frame base; LEAVE: results kept (0 or 1).
REQ-009 index  output  DEPTH+1  entry count (next free slot).
REQ-010 base  output  DEPTH+1  current frame base.
REQ-011 frame  output  FDEPTH+1  number of saved frame records.
REQ-012 tos  output  WIDTH  entry index-1, 0 if index<1.
REQ-013 nos  output  WIDTH  entry index-2, 0 if index<2.
REQ-014 get_data  output  WIDTH  result of last successful GET.
REQ-015 status  output  4  0 NONE, 1 EMPTY, 2 FULL, 3 UNDERFLOW, 4 OVERFLOW, 5 BAD_OFFSET, 6 FRAME_OVERFLOW, 7 FRAME_UNDERFLOW, 8 BAD_OP.

Function
REQ-016 All outputs registered; effect of op at edge N visible after edge N; one op per cycle, no stall.
REQ-017 Success status after any op: FULL if index==MAX, else EMPTY if index==base, else NONE.
REQ-018 Any error leaves index, base, frame, memory, tos, nos, get_data unchanged; only status updates.
REQ-019 NOP: no state change; status recomputed per REQ-017.
REQ-020 PUSH: index==MAX -> OVERFLOW; else mem[index]<=data, index+1, nos<=old tos, tos<=data.
REQ-021 POP: index==base -> UNDERFLOW; else index-1, tos<=old nos, nos<=mem[index-3] (0 if index<3).
REQ-022 REPLACE: index==base -> UNDERFLOW; else mem[index-1]<=data, tos<=data.
REQ-023 POP2_PUSH: index-base<2 -> UNDERFLOW; else mem[index-2]<=data, index-1, tos<=data, nos<=mem[index-3] (0 if index<3).
REQ-024 ENTER: frame==FMAX -> FRAME_OVERFLOW; arg>index-base -> UNDERFLOW; else save old base as record, frame+1, base<=index-arg.
REQ-025 LEAVE: frame==0 -> FRAME_UNDERFLOW; arg>1 -> BAD_OFFSET; arg==1 and index==base -> UNDERFLOW; else restore saved base, frame-1, index<=old base+arg; arg==1 copies old tos to mem[old base].
REQ-026 LEAVE: tos/nos reflect resulting top two entries (0 where absent).
REQ-027 GET: base+arg>=index -> BAD_OFFSET; else get_data<=mem[base+arg].
REQ-028 SET: base+arg>=index -> BAD_OFFSET; else mem[base+arg]<=data; tos/nos updated when the target is entry index-1/index-2.
REQ-029 Ops 9-15 -> BAD_OP.
REQ-030 Offset/limit comparisons done at DEPTH+1 bits without wrap; base+arg overflow treated as BAD_OFFSET.
REQ-031 Memory contents undefined until written; never read out beyond index.

Reset
REQ-032 reset dominates op; index, base, frame, tos, nos, get_data <=0, status<=EMPTY next edge.
REQ-033 reset mid-sequence discards all frame records; memory contents not cleared.

Verification
REQ-034 reset; PUSH 5,7,9 -> index=3, tos=9, nos=7, status NONE; POP -> tos=7, nos=5.
REQ-035 PUSH 3,4; POP2_PUSH data=7 -> index=1, tos=7, nos=0; POP2_PUSH -> UNDERFLOW, no change.
REQ-036 PUSH 1,2,3; ENTER arg=2 -> base=1, frame=1; GET arg=1 -> get_data=3; POP,POP -> EMPTY; POP -> UNDERFLOW.
REQ-037 From REQ-036 after ENTER: PUSH 9; LEAVE arg=1 -> base=0, frame=0, index=2, tos=9, nos=1.
REQ-038 DEPTH=2: PUSH x4 -> FULL; PUSH -> OVERFLOW index=4; LEAVE with frame=0 -> FRAME_UNDERFLOW; op=12 -> BAD_OP.
REQ-039 Mid-frame reset asserted with op=PUSH -> index=0, frame=0, status EMPTY, push ignored.
